// File: rtl/nanorv32_wb_unit.sv
// nanorv32_wb_unit: write-back stage of the NANORV32 core.
// Merges ALU results and load responses onto the register file write port,
// aligns/extends load data, tracks the single outstanding load and flags
// read-after-write hazards on the register file read selectors.
// Optional feature macro: NANORV32_WB_MISALIGN_CHECK_EN (misaligned load rejection).
module nanorv32_wb_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd_sel,
  input  logic [31:0] alu_result,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd_sel,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lsb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  sel_porta,
  input  logic [4:0]  sel_portb,
  output logic [4:0]  sel_rd,
  output logic [31:0] rd,
  output logic        write_rd,
  output logic        ld_busy,
  output logic        stall_alu,
  output logic        raw_hazard,
  output logic        ld_misalign
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  ld_rd_q;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_lsb_q;
  logic        skid_full_q, skid_full_d;
  logic [4:0]  skid_rd_q, skid_rd_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic [4:0]  sel_rd_q, sel_rd_d;
  logic [31:0] rd_q, rd_d;
  logic        write_rd_q, write_rd_d;

  logic        ld_resp;
  logic        ld_accept;
  logic        misalign_bad;
  logic [31:0] ld_data;
  logic        alu_take;
  logic        win_valid;
  logic [4:0]  win_rd;
  logic [31:0] win_data;

  // A new load can be taken when idle, or in the cycle the previous one completes
  logic issue_slot;
  assign issue_slot = ld_issue && ((state_q == S_IDLE) || mem_rvalid);

`ifdef NANORV32_WB_MISALIGN_CHECK_EN
  logic ld_misalign_q;
  // Halfwords must be 2-byte aligned, words 4-byte aligned
  assign misalign_bad = issue_slot &&
                        (((ld_funct3[1:0] == 2'b01) && ld_addr_lsb[0]) ||
                         ((ld_funct3 == 3'b010) && (ld_addr_lsb != 2'b00)));
  // One-cycle registered pulse following a rejected issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ld_misalign_q <= 1'b0;
    else     ld_misalign_q <= misalign_bad;
  end
  assign ld_misalign = ld_misalign_q;
`else
  assign misalign_bad = 1'b0;
  assign ld_misalign  = 1'b0;
`endif

  // Load tracker next state: a completing response and a new issue may coincide
  always_comb begin
    state_d   = state_q;
    ld_resp   = (state_q == S_WAIT) && mem_rvalid;
    ld_accept = issue_slot && !misalign_bad;
    if (ld_accept)    state_d = S_WAIT;
    else if (ld_resp) state_d = S_IDLE;
  end

  assign ld_busy = (state_q == S_WAIT) && !mem_rvalid;

  // Extract and extend load data from the latched type and byte offset
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = mem_rdata[{ld_lsb_q, 3'b000} +: 8];
    half_sel = ld_lsb_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_funct3_q)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_data = {24'd0, byte_sel};
      3'b101:  ld_data = {16'd0, half_sel};
      default: ld_data = mem_rdata;
    endcase
  end

  // Write-port arbitration: load response, then skid buffer, then new ALU result
  always_comb begin
    alu_take    = alu_valid && !skid_full_q;
    win_valid   = 1'b0;
    win_rd      = 5'd0;
    win_data    = 32'd0;
    skid_full_d = skid_full_q;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    if (ld_resp) begin
      win_valid = 1'b1;
      win_rd    = ld_rd_q;
      win_data  = ld_data;
      if (alu_take) begin
        skid_full_d = 1'b1;
        skid_rd_d   = alu_rd_sel;
        skid_data_d = alu_result;
      end
    end else if (skid_full_q) begin
      win_valid   = 1'b1;
      win_rd      = skid_rd_q;
      win_data    = skid_data_q;
      skid_full_d = 1'b0;
    end else if (alu_take) begin
      win_valid = 1'b1;
      win_rd    = alu_rd_sel;
      win_data  = alu_result;
    end
    // x0 writes consume the slot but never assert the enable
    write_rd_d = win_valid && (win_rd != 5'd0);
    sel_rd_d   = win_valid ? win_rd   : sel_rd_q;
    rd_d       = win_valid ? win_data : rd_q;
  end

  // State, load context, skid buffer and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ld_rd_q     <= 5'd0;
      ld_funct3_q <= 3'd0;
      ld_lsb_q    <= 2'd0;
      skid_full_q <= 1'b0;
      skid_rd_q   <= 5'd0;
      skid_data_q <= 32'd0;
      sel_rd_q    <= 5'd0;
      rd_q        <= 32'd0;
      write_rd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ld_accept) begin
        ld_rd_q     <= ld_rd_sel;
        ld_funct3_q <= ld_funct3;
        ld_lsb_q    <= ld_addr_lsb;
      end
      skid_full_q <= skid_full_d;
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
      sel_rd_q    <= sel_rd_d;
      rd_q        <= rd_d;
      write_rd_q  <= write_rd_d;
    end
  end

  assign sel_rd    = sel_rd_q;
  assign rd        = rd_q;
  assign write_rd  = write_rd_q;
  assign stall_alu = skid_full_q;

  // Hazard: a nonzero read selector matching any destination not yet in the file
  logic hit_a, hit_b;
  always_comb begin
    hit_a = (sel_porta != 5'd0) &&
            (((state_q == S_WAIT) && (sel_porta == ld_rd_q)) ||
             (skid_full_q && (sel_porta == skid_rd_q)) ||
             (write_rd_q && (sel_porta == sel_rd_q)));
    hit_b = (sel_portb != 5'd0) &&
            (((state_q == S_WAIT) && (sel_portb == ld_rd_q)) ||
             (skid_full_q && (sel_portb == skid_rd_q)) ||
             (write_rd_q && (sel_portb == sel_rd_q)));
  end
  assign raw_hazard = hit_a || hit_b;

endmodule

// File: tb/tb_nanorv32_wb_unit.sv
// Testbench for nanorv32_wb_unit: directed vectors, expected register writes
// queued by the stimulus and checked by an independent write-port monitor.
module tb_nanorv32_wb_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd_sel = 5'd0;
  logic [31:0] alu_result = 32'd0;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_rd_sel = 5'd0;
  logic [2:0]  ld_funct3 = 3'd0;
  logic [1:0]  ld_addr_lsb = 2'd0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [4:0]  sel_porta = 5'd0;
  logic [4:0]  sel_portb = 5'd0;
  logic [4:0]  sel_rd;
  logic [31:0] rd;
  logic        write_rd;
  logic        ld_busy;
  logic        stall_alu;
  logic        raw_hazard;
  logic        ld_misalign;

  nanorv32_wb_unit dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd_sel(alu_rd_sel), .alu_result(alu_result),
    .ld_issue(ld_issue), .ld_rd_sel(ld_rd_sel), .ld_funct3(ld_funct3),
    .ld_addr_lsb(ld_addr_lsb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .sel_porta(sel_porta), .sel_portb(sel_portb),
    .sel_rd(sel_rd), .rd(rd), .write_rd(write_rd), .ld_busy(ld_busy),
    .stall_alu(stall_alu), .raw_hazard(raw_hazard), .ld_misalign(ld_misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected write
  always @(negedge clk) begin
    if (!rst && write_rd) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got x%0d=0x%08h expected no write", sel_rd, rd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk($sformatf("write_sel(x%0d)", e.sel), {27'd0, sel_rd}, {27'd0, e.sel});
        chk($sformatf("write_data(x%0d)", e.sel), rd, e.data);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] s, input logic [31:0] d);
    wr_t e;
    e.sel  = s;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic alu(input logic [4:0] s, input logic [31:0] d);
    alu_valid = 1'b1; alu_rd_sel = s; alu_result = d;
  endtask

  task automatic issue(input logic [4:0] s, input logic [2:0] f3, input logic [1:0] lsb);
    ld_issue = 1'b1; ld_rd_sel = s; ld_funct3 = f3; ld_addr_lsb = lsb;
  endtask

  task automatic resp(input logic [31:0] d);
    mem_rvalid = 1'b1; mem_rdata = d;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; ld_issue = 1'b0; mem_rvalid = 1'b0;
  endtask

  // Single load: issue, one cycle later respond, expect extracted value
  task automatic do_load(input logic [4:0] s, input logic [2:0] f3, input logic [1:0] lsb,
                         input logic [31:0] rdata, input logic [31:0] exp);
    issue(s, f3, lsb);
    cycle();
    idle_inputs();
    resp(rdata);
    expect_wr(s, exp);
    cycle();
    idle_inputs();
  endtask

  initial begin
    // Reset state
    repeat (2) cycle();
    rst = 1'b0;
    sel_porta = 5'd5;
    #1;
    chk("reset_sel_rd", {27'd0, sel_rd}, 32'd0);
    chk("reset_rd", rd, 32'd0);
    chk("reset_write_rd", {31'd0, write_rd}, 32'd0);
    chk("reset_stall_alu", {31'd0, stall_alu}, 32'd0);
    chk("reset_ld_misalign", {31'd0, ld_misalign}, 32'd0);
    chk("reset_ld_busy", {31'd0, ld_busy}, 32'd0);
    chk("reset_raw_hazard", {31'd0, raw_hazard}, 32'd0);
    cycle();

    // ALU write, then hazard against the pending write-port entry
    alu(5'd5, 32'h12345678);
    expect_wr(5'd5, 32'h12345678);
    cycle();
    idle_inputs();
    #1;
    chk("hazard_sel_rd_x5", {31'd0, raw_hazard}, 32'd1);
    sel_porta = 5'd0;
    #1;
    chk("hazard_sel_x0", {31'd0, raw_hazard}, 32'd0);
    cycle();

    // LB with busy/hazard checks while waiting
    issue(5'd10, 3'b000, 2'd3);
    cycle();
    idle_inputs();
    sel_portb = 5'd10;
    #1;
    chk("ld_busy_wait", {31'd0, ld_busy}, 32'd1);
    chk("hazard_load_x10", {31'd0, raw_hazard}, 32'd1);
    sel_portb = 5'd0;
    resp(32'h80FF7F01);
    #1;
    chk("ld_busy_resp", {31'd0, ld_busy}, 32'd0);
    expect_wr(5'd10, 32'hFFFFFF80);
    cycle();
    idle_inputs();

    // Remaining load types
    do_load(5'd11, 3'b101, 2'd2, 32'h80FF7F01, 32'h000080FF);
    do_load(5'd12, 3'b001, 2'd0, 32'h1234F00D, 32'hFFFFF00D);
    do_load(5'd16, 3'b100, 2'd1, 32'h00009A00, 32'h0000009A);
    do_load(5'd13, 3'b010, 2'd0, 32'hA5A5C3C3, 32'hA5A5C3C3);
    do_load(5'd17, 3'b000, 2'd1, 32'h00007F00, 32'h0000007F);

    // Collision: load response and ALU result in the same cycle
    issue(5'd7, 3'b010, 2'd0);
    cycle();
    idle_inputs();
    resp(32'hDEADBEEF);
    alu(5'd8, 32'h0000000A);
    expect_wr(5'd7, 32'hDEADBEEF);
    expect_wr(5'd8, 32'h0000000A);
    cycle();
    idle_inputs();
    sel_porta = 5'd8;
    #1;
    chk("collision_stall_alu", {31'd0, stall_alu}, 32'd1);
    chk("hazard_skid_x8", {31'd0, raw_hazard}, 32'd1);
    sel_porta = 5'd0;
    cycle();
    chk("collision_stall_clear", {31'd0, stall_alu}, 32'd0);
    cycle();

    // Back-to-back loads: new issue in the response cycle
    issue(5'd14, 3'b010, 2'd0);
    cycle();
    idle_inputs();
    resp(32'h11111111);
    issue(5'd15, 3'b100, 2'd0);
    expect_wr(5'd14, 32'h11111111);
    cycle();
    idle_inputs();
    #1;
    chk("b2b_ld_busy", {31'd0, ld_busy}, 32'd1);
    resp(32'h000000FE);
    expect_wr(5'd15, 32'h000000FE);
    cycle();
    idle_inputs();

    // Load to x3 pending: hazard on nonzero selector only
    issue(5'd3, 3'b010, 2'd0);
    cycle();
    idle_inputs();
    sel_porta = 5'd3;
    #1;
    chk("hazard_load_x3", {31'd0, raw_hazard}, 32'd1);
    sel_porta = 5'd0;
    #1;
    chk("hazard_x0_selector", {31'd0, raw_hazard}, 32'd0);
    resp(32'h00000333);
    expect_wr(5'd3, 32'h00000333);
    cycle();
    idle_inputs();

    // ALU to x0: no write enable
    alu(5'd0, 32'hFFFFFFFF);
    cycle();
    idle_inputs();
    chk("x0_write_rd", {31'd0, write_rd}, 32'd0);

    // Sustained throughput: one ALU write per cycle
    for (int i = 1; i <= 3; i++) begin
      alu(5'(20 + i), 32'h100 * i);
      expect_wr(5'(20 + i), 32'h100 * i);
      cycle();
    end
    idle_inputs();
    cycle();

    // Reset mid-load: outstanding load discarded, late response ignored
    issue(5'd20, 3'b010, 2'd0);
    cycle();
    idle_inputs();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_ld_busy", {31'd0, ld_busy}, 32'd0);
    resp(32'h55555555);
    cycle();
    idle_inputs();
    chk("rst_late_resp_write_rd", {31'd0, write_rd}, 32'd0);
    chk("rst_late_ld_busy", {31'd0, ld_busy}, 32'd0);

    // LW with lsb=2
`ifdef NANORV32_WB_MISALIGN_CHECK_EN
    issue(5'd21, 3'b010, 2'd2);
    cycle();
    idle_inputs();
    chk("misalign_pulse", {31'd0, ld_misalign}, 32'd1);
    chk("misalign_ld_busy", {31'd0, ld_busy}, 32'd0);
    resp(32'hCAFEF00D);
    cycle();
    idle_inputs();
    chk("misalign_pulse_end", {31'd0, ld_misalign}, 32'd0);
    chk("misalign_no_write", {31'd0, write_rd}, 32'd0);
`else
    do_load(5'd21, 3'b010, 2'd2, 32'hCAFEF00D, 32'hCAFEF00D);
    chk("no_misalign_flag", {31'd0, ld_misalign}, 32'd0);
`endif

    repeat (3) cycle();
    chk("pending_writes_left", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
